// File: rtl/aes_seq_pkg.sv
// Shared types and helpers for the AES-128 byte sequencer: FSM state encoding,
// block geometry and MSB-first byte selection.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CRST    = 3'd1,
        LOAD    = 3'd2,
        WAIT    = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    localparam int AES_NBYTES  = 16;
    localparam int AES_BLOCK_W = 128;

    // Byte idx of a 128-bit word, byte 0 being bits [127:120].
    function automatic logic [7:0] byte_sel(input logic [AES_BLOCK_W-1:0] vec,
                                            input logic [3:0]             idx);
        logic [AES_NBYTES-1:0][7:0] v;
        v = vec;
        return v[4'd15 - idx];
    endfunction

endpackage

// File: rtl/aes_seq_bytecnt.sv
// 4-bit byte index counter with synchronous clear/enable and a last-byte flag;
// used for both the load stream and the ciphertext collection.
module aes_seq_bytecnt
    import aes_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       last
);

    logic [3:0] cnt_r;

    // Byte index register: clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (clr) begin
            cnt_r <= 4'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == 4'(AES_NBYTES - 1));

endmodule

// File: rtl/aes_byte_sequencer.sv
// Drives one AES-128 block through the byte-serial core: reset, 16-byte load, 16-byte collect, handshake.
// Optional abort watchdog in WAIT/COLLECT is compiled in when AES_SEQ_TIMEOUT_EN is defined.
module aes_byte_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NBYTES     = 16,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 2048
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] block_in,
    output logic         busy,
    output logic [127:0] result,
    output logic         result_vld,
    input  logic         result_ack,
    output logic         error,
    output logic         core_rst,
    output logic [7:0]   core_key,
    output logic [7:0]   core_din,
    input  logic [7:0]   core_dout,
    input  logic         core_vld,
    input  logic         core_done
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_t                 state_r;
    logic [AES_BLOCK_W-1:0]     key_sh_r;
    logic [AES_BLOCK_W-1:0]     blk_sh_r;
    logic [AES_NBYTES-1:0][7:0] result_r;
    logic                       busy_r;
    logic                       result_vld_r;
    logic                       error_r;
    logic                       core_rst_r;
    logic [7:0]                 core_key_r;
    logic [7:0]                 core_din_r;
    logic [RST_W-1:0]           rst_cnt_r;

    logic [3:0] ld_cnt_s;
    logic [3:0] col_cnt_s;
    logic       ld_last_s;
    logic       col_last_s;
    logic       ld_clr_s;
    logic       ld_en_s;
    logic       col_clr_s;
    logic       col_en_s;
    logic       tmo_hit_s;

    // Counter controls derived from the current state.
    always_comb begin
        ld_clr_s  = (state_r != LOAD);
        ld_en_s   = (state_r == LOAD);
        col_clr_s = (state_r == IDLE);
        col_en_s  = core_vld && ((state_r == WAIT) || (state_r == COLLECT));
    end

    aes_seq_bytecnt u_ld_cnt (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .clr   (ld_clr_s),
        .en    (ld_en_s),
        .cnt   (ld_cnt_s),
        .last  (ld_last_s)
    );

    aes_seq_bytecnt u_col_cnt (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .clr   (col_clr_s),
        .en    (col_en_s),
        .cnt   (col_cnt_s),
        .last  (col_last_s)
    );

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Watchdog: runs only while waiting on the core, zero everywhere else.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == WAIT) || (state_r == COLLECT)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign tmo_hit_s = ((state_r == WAIT) || (state_r == COLLECT)) &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Sequencer FSM with all bus- and core-facing outputs registered.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r      <= IDLE;
            key_sh_r     <= '0;
            blk_sh_r     <= '0;
            result_r     <= '0;
            busy_r       <= 1'b0;
            result_vld_r <= 1'b0;
            error_r      <= 1'b0;
            core_rst_r   <= 1'b1;
            core_key_r   <= 8'd0;
            core_din_r   <= 8'd0;
            rst_cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    core_rst_r <= 1'b1;
                    core_key_r <= 8'd0;
                    core_din_r <= 8'd0;
                    if (start) begin
                        key_sh_r  <= key;
                        blk_sh_r  <= block_in;
                        busy_r    <= 1'b1;
                        error_r   <= 1'b0;
                        rst_cnt_r <= '0;
                        state_r   <= CRST;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CRST: begin
                    if (rst_cnt_r == RST_W'(RST_CYCLES - 1)) begin
                        core_rst_r <= 1'b0;
                        core_key_r <= byte_sel(key_sh_r, 4'd0);
                        core_din_r <= byte_sel(blk_sh_r, 4'd0);
                        state_r    <= LOAD;
                    end else begin
                        rst_cnt_r  <= rst_cnt_r + RST_W'(1);
                    end
                end
                LOAD: begin
                    // Outputs present byte ld_cnt_s now, so preload the next one.
                    if (ld_last_s) begin
                        core_key_r <= 8'd0;
                        core_din_r <= 8'd0;
                        state_r    <= WAIT;
                    end else begin
                        core_key_r <= byte_sel(key_sh_r, ld_cnt_s + 4'd1);
                        core_din_r <= byte_sel(blk_sh_r, ld_cnt_s + 4'd1);
                    end
                end
                WAIT, COLLECT: begin
                    if (tmo_hit_s) begin
                        error_r    <= 1'b1;
                        busy_r     <= 1'b0;
                        core_rst_r <= 1'b1;
                        state_r    <= IDLE;
                    end else if (core_vld) begin
                        result_r[4'd15 - col_cnt_s] <= core_dout;
                        if (col_last_s) begin
                            result_vld_r <= 1'b1;
                            core_rst_r   <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            state_r      <= COLLECT;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_vld_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= DONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    core_rst_r <= 1'b1;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign result     = result_r;
    assign result_vld = result_vld_r;
    assign error      = error_r;
    assign core_rst   = core_rst_r;
    assign core_key   = core_key_r;
    assign core_din   = core_din_r;

    // core_done is informational only; geometry is fixed at 16 bytes.
    logic unused_cfg_s;
    assign unused_cfg_s = core_done ^ (NBYTES != AES_NBYTES) ^ (TIMEOUT == 0);

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Self-checking bench for aes_byte_sequencer: a vector table plus random blocks through a
// behavioural byte-serial core model; reset-in-collect and (optional) watchdog sequences.
module tb_aes_byte_sequencer;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] IDX_PAT  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] block_in = '0;
    logic         busy;
    logic [127:0] result;
    logic         result_vld;
    logic         result_ack = 1'b0;
    logic         error;
    logic         core_rst;
    logic [7:0]   core_key;
    logic [7:0]   core_din;
    logic [7:0]   core_dout = 8'd0;
    logic         core_vld = 1'b0;
    logic         core_done = 1'b0;

    aes_byte_sequencer #(.NBYTES(16), .RST_CYCLES(2), .TIMEOUT(64)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start      (start),
        .key        (key),
        .block_in   (block_in),
        .busy       (busy),
        .result     (result),
        .result_vld (result_vld),
        .result_ack (result_ack),
        .error      (error),
        .core_rst   (core_rst),
        .core_key   (core_key),
        .core_din   (core_din),
        .core_dout  (core_dout),
        .core_vld   (core_vld),
        .core_done  (core_done)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        int           gap;
        logic         poke;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl[4];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: stand-in cipher = pt ^ nibble-swapped key ^ byte-index pattern.
    function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] m;
        m = {16{8'hf0}};
        return p ^ (((k & m) >> 4) | ((k & ~m) << 4)) ^ IDX_PAT;
    endfunction

    // Core model: reacts to the byte streams it actually received.
    function automatic logic [127:0] core_model(input logic [127:0] ks, input logic [127:0] ds);
        logic [127:0] o;
        logic [7:0]   kb;
        if (ks == FIPS_KEY && ds == FIPS_PT) return FIPS_CT;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            kb = ks[127 - 8*i -: 8];
            o[127 - 8*i -: 8] = ds[127 - 8*i -: 8] ^ {kb[3:0], kb[7:4]} ^ 8'(i);
        end
        return o;
    endfunction

    task automatic issue_start(input logic [127:0] k, input logic [127:0] p);
        start = 1'b1; key = k; block_in = p;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    // Counts core reset cycles, then records 16 load bytes while poking junk core_vld.
    task automatic do_load(input logic poke, output logic [127:0] ks, output logic [127:0] ds,
                           output int rst_hi, output logic rst_ok);
        int w;
        rst_hi = 0; w = 0; rst_ok = 1'b1; ks = '0; ds = '0;
        while (core_rst === 1'b1 && w < 50) begin
            rst_hi++; w++;
            @(negedge HCLK);
        end
        for (int i = 0; i < 16; i++) begin
            ks = {ks[119:0], core_key};
            ds = {ds[119:0], core_din};
            if (core_rst !== 1'b0) rst_ok = 1'b0;
            core_vld  = (i < 15);
            core_dout = 8'hee;
            start     = poke && (i == 5);
            if (poke && i == 5) key = ~key;
            @(negedge HCLK);
        end
        core_vld = 1'b0;
        start    = 1'b0;
    endtask

    task automatic feed(input logic [127:0] ob, input int gap, input int nb, output logic busy_ok);
        busy_ok = 1'b1;
        repeat (3) @(negedge HCLK);
        for (int i = 0; i < nb; i++) begin
            core_vld  = 1'b1;
            core_dout = ob[127 - 8*i -: 8];
            @(negedge HCLK);
            if (i < 15 && busy !== 1'b1) busy_ok = 1'b0;
            core_vld  = 1'b0;
            core_dout = 8'($urandom());
            for (int g = 0; g < gap; g++) begin
                @(negedge HCLK);
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
    endtask

    task automatic run_block(input vec_t v, input string nm);
        logic [127:0] ks, ds;
        int           rst_hi, w;
        logic         rst_ok, busy_ok;
        issue_start(v.key, v.pt);
        check($sformatf("%s_busy_start", nm), busy, 1);
        do_load(v.poke, ks, ds, rst_hi, rst_ok);
        check($sformatf("%s_rst_cycles", nm), rst_hi, 2);
        check($sformatf("%s_load_key", nm), ks, v.key);
        check($sformatf("%s_load_din", nm), ds, v.pt);
        check($sformatf("%s_rst_low_in_load", nm), rst_ok, 1);
        check($sformatf("%s_wait_bytes_zero", nm), {core_key, core_din}, 0);
        feed(core_model(ks, ds), v.gap, 16, busy_ok);
        core_vld = 1'b1; core_dout = 8'h5a; core_done = 1'b1;
        @(negedge HCLK);
        core_done = 1'b0;
        @(negedge HCLK);
        core_vld = 1'b0;
        w = 0;
        while (result_vld !== 1'b1 && w < 20) begin
            @(negedge HCLK);
            w++;
        end
        check($sformatf("%s_result_vld", nm), result_vld, 1);
        check($sformatf("%s_result", nm), result, v.exp);
        check($sformatf("%s_busy_held", nm), busy_ok, 1);
        for (int h = 0; h < 3; h++) begin
            start = v.poke && (h == 0);
            key   = ~v.key;
            @(negedge HCLK);
            start = 1'b0;
        end
        check($sformatf("%s_vld_held", nm), {busy, result_vld}, 2'b11);
        result_ack = 1'b1;
        start      = v.poke;
        @(negedge HCLK);
        result_ack = 1'b0;
        start      = 1'b0;
        check($sformatf("%s_after_ack", nm), {busy, result_vld, core_rst}, 3'b001);
        @(negedge HCLK);
        check($sformatf("%s_idle_busy", nm), busy, 0);
        check($sformatf("%s_result_hold", nm), result, v.exp);
    endtask

    logic [127:0] kstr, dstr;
    int           rst_cnt, w;
    logic         rst_ok, bok;
    vec_t         rv;

    initial begin
        tbl[0] = '{FIPS_KEY, FIPS_PT, 0, 1'b0, FIPS_CT};
        tbl[1] = '{FIPS_KEY, FIPS_PT, 3, 1'b0, FIPS_CT};
        tbl[2] = '{{16{8'hff}}, 128'h0, 1, 1'b0, ref_cipher({16{8'hff}}, 128'h0)};
        tbl[3] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, {16{8'ha5}}, 0, 1'b1,
                   ref_cipher(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, {16{8'ha5}})};

        repeat (3) @(negedge HCLK);
        check("reset_flags", {busy, result_vld, error, core_rst}, 4'b0001);
        check("reset_result", result, 0);
        check("reset_core_bytes", {core_key, core_din}, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int t = 0; t < 4; t++) run_block(tbl[t], $sformatf("vec%0d", t));

        // Reset while collecting, after byte 7 has been taken.
        issue_start(FIPS_KEY, FIPS_PT);
        do_load(1'b0, kstr, dstr, rst_cnt, rst_ok);
        feed(core_model(kstr, dstr), 0, 8, bok);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("midreset_flags", {busy, result_vld, error, core_rst}, 4'b0001);
        check("midreset_result", result, 0);
        check("midreset_core_bytes", {core_key, core_din}, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        run_block(tbl[0], "post_reset");

        for (int r = 0; r < 6; r++) begin
            rv.key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rv.pt   = {$urandom(), $urandom(), $urandom(), $urandom()};
            rv.gap  = $urandom_range(0, 3);
            rv.poke = 1'b0;
            rv.exp  = ref_cipher(rv.key, rv.pt);
            run_block(rv, $sformatf("rand%0d", r));
        end

`ifdef AES_SEQ_TIMEOUT_EN
        issue_start(tbl[2].key, tbl[2].pt);
        do_load(1'b0, kstr, dstr, rst_cnt, rst_ok);
        w = 0;
        while (error !== 1'b1 && w < 200) begin
            @(negedge HCLK);
            w++;
        end
        check("tmo_cycles", w, 64);
        check("tmo_flags", {busy, result_vld, error, core_rst}, 4'b0011);
        issue_start(tbl[2].key, tbl[2].pt);
        check("tmo_error_cleared", {busy, error}, 2'b10);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
